template_match_scorer: RTL



---
 rtl/template_match_scorer_pkg.sv | 18 +
 rtl/template_match_scorer.sv | 115 +++++++++++
 2 files changed

// File: rtl/template_match_scorer_pkg.sv
// Shared constants and state encoding for the template match scorer.
// The same geometry constants size the template ROM and the scan window logic.
package template_match_scorer_pkg;

    localparam int TPL_W   = 26;
    localparam int TPL_H   = 26;
    localparam int TPL_N   = TPL_W * TPL_H;
    localparam int ADDR_W  = 10;
    localparam int SCORE_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/template_match_scorer.sv
// Streams one patch against the template ROM, counts binary pixel agreements,
// and reports score/detect once per patch.
//
// state    | meaning
// ST_IDLE  | waiting for start; thresholds latched on start
// ST_RUN   | accepting pixels, ROM address tracks the pixel index
// ST_DRAIN | compare for the final pixel retires
// ST_DONE  | done pulse; score/detect were registered on entry
module template_match_scorer #(
    parameter int TPL_N   = template_match_scorer_pkg::TPL_N,
    parameter int ADDR_W  = template_match_scorer_pkg::ADDR_W,
    parameter int SCORE_W = template_match_scorer_pkg::SCORE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         bin_threshold,
    input  logic [SCORE_W-1:0] match_threshold,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    output logic               pix_ready,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [7:0]         rom_data,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic               detect
);
    import template_match_scorer_pkg::*;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_idx;
    logic [SCORE_W-1:0] r_acc;
    logic [SCORE_W-1:0] w_acc_next;
    logic [SCORE_W-1:0] r_match_thr;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_bin_thr;
    logic               r_pbit;
    logic               r_cmp_valid;
    logic               r_detect;
    logic               w_handshake;
    logic               w_last;
    logic               w_tbit;
    logic               w_start_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (w_handshake && w_last) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign pix_ready   = (r_state == ST_RUN);
    assign w_handshake = pix_valid && pix_ready;
    assign w_last      = (r_idx == ADDR_W'(TPL_N - 1));
    // Address follows the index directly so a stall re-reads the same ROM word.
    assign rom_address = (r_state == ST_RUN) ? r_idx : '0;
    assign w_tbit      = (rom_data != 8'd0);
    assign w_acc_next  = (r_cmp_valid && (r_pbit == w_tbit)) ? r_acc + SCORE_W'(1) : r_acc;

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign score  = r_score;
    assign detect = r_detect;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx       <= '0;
            r_bin_thr   <= '0;
            r_match_thr <= '0;
            r_pbit      <= 1'b0;
            r_cmp_valid <= 1'b0;
        end else begin
            r_cmp_valid <= w_handshake;
            if (w_start_ok) begin
                r_idx       <= '0;
                r_bin_thr   <= bin_threshold;
                r_match_thr <= match_threshold;
            end else if (w_handshake) begin
                r_idx  <= r_idx + ADDR_W'(1);
                r_pbit <= (pix_data >= r_bin_thr);
            end
        end
    end

    // Score is taken from the DRAIN-cycle accumulator update so the last compare counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_score  <= '0;
            r_detect <= 1'b0;
        end else begin
            r_acc <= w_start_ok ? '0 : w_acc_next;
            if (r_state == ST_DRAIN) begin
                r_score  <= w_acc_next;
                r_detect <= (w_acc_next >= r_match_thr);
            end
        end
    end

endmodule
